// File: rtl/alu_calc_pkg.sv
// Shared types and defaults for the single-button ALU calculator.
package alu_calc_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_SEL_W = 3;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    localparam logic [4:0] STEP_A    = 5'b00001;
    localparam logic [4:0] STEP_B    = 5'b00010;
    localparam logic [4:0] STEP_OP   = 5'b00100;
    localparam logic [4:0] STEP_EXEC = 5'b01000;
    localparam logic [4:0] STEP_SHOW = 5'b10000;

endpackage

// File: rtl/alu_sequencer.sv
// Five-step entry sequencer: operand A, operand B, opcode, execute, show.
module alu_sequencer
    import alu_calc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enter,
    input  logic                 clr,
    input  logic                 chain,
    input  logic [WIDTH-1:0]     in,
    input  logic [2*WIDTH-1:0]   alu_y,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    output logic [SEL_W-1:0]     op_sel,
    output logic [2*WIDTH-1:0]   result,
    output logic [2*WIDTH-1:0]   disp,
    output logic                 done,
    output logic [4:0]           step,
    output logic [7:0]           op_count
);

    state_t state, next_state;
    logic   ld_a, ld_chain, ld_b, ld_sel, exec;

    always_ff @(posedge clk) begin
        if (rst) state <= S_A;
        else     state <= next_state;
    end

    // clr overrides everything, so no load strobe fires in that cycle
    always_comb begin
        next_state = state;
        ld_a       = 1'b0;
        ld_chain   = 1'b0;
        ld_b       = 1'b0;
        ld_sel     = 1'b0;
        exec       = 1'b0;
        if (clr) begin
            next_state = S_A;
        end else begin
            case (state)
                S_A: if (enter) begin
                    ld_a       = 1'b1;
                    next_state = S_B;
                end
                S_B: if (enter) begin
                    ld_b       = 1'b1;
                    next_state = S_OP;
                end
                S_OP: if (enter) begin
                    ld_sel     = 1'b1;
                    next_state = S_EXEC;
                end
                S_EXEC: begin
                    exec       = 1'b1;
                    next_state = S_SHOW;
                end
                S_SHOW: if (enter) begin
                    ld_chain   = chain;
                    next_state = chain ? S_B : S_A;
                end
                default: next_state = S_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            op_sel   <= '0;
            result   <= '0;
            done     <= 1'b0;
            op_count <= '0;
        end else begin
            done <= exec;
            if (clr) begin
                op_a   <= '0;
                op_b   <= '0;
                op_sel <= '0;
                result <= '0;
            end
            if (ld_a)     op_a   <= in;
            if (ld_chain) op_a   <= result[WIDTH-1:0];
            if (ld_b)     op_b   <= in;
            if (ld_sel)   op_sel <= in[SEL_W-1:0];
            if (exec) begin
                result   <= alu_y;
                op_count <= op_count + 8'd1;
            end
        end
    end

    always_comb begin
        step = STEP_A;
        disp = {{WIDTH{1'b0}}, in};
        case (state)
            S_A:    step = STEP_A;
            S_B:    step = STEP_B;
            S_OP: begin
                step = STEP_OP;
                disp = {{(2*WIDTH-SEL_W){1'b0}}, in[SEL_W-1:0]};
            end
            S_EXEC: begin
                step = STEP_EXEC;
                disp = result;
            end
            S_SHOW: begin
                step = STEP_SHOW;
                disp = result;
            end
            default: step = STEP_A;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with a phase-level reference model; alu_y = a*b.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enter = 1'b0;
    logic        clr = 1'b0;
    logic        chain = 1'b0;
    logic [7:0]  in = 8'h00;
    logic [15:0] alu_y;
    logic [7:0]  op_a, op_b;
    logic [2:0]  op_sel;
    logic [15:0] result, disp;
    logic        done;
    logic [4:0]  step;
    logic [7:0]  op_count;

    int total = 0;
    int bad = 0;

    int          m_phase;
    logic [7:0]  m_a, m_b, m_cnt;
    logic [2:0]  m_sel;
    logic [15:0] m_res;
    logic        m_done;

    always #5 clk = ~clk;

    assign alu_y = op_a * op_b;

    alu_sequencer #(.WIDTH(8), .SEL_W(3)) dut (
        .clk(clk), .rst(rst), .enter(enter), .clr(clr), .chain(chain),
        .in(in), .alu_y(alu_y), .op_a(op_a), .op_b(op_b),
        .op_sel(op_sel), .result(result), .disp(disp), .done(done),
        .step(step), .op_count(op_count)
    );

    task automatic model_reset();
        m_phase = 0; m_a = 0; m_b = 0; m_sel = 0;
        m_res = 0; m_done = 0; m_cnt = 0;
    endtask

    // Phase 0..4 = A, B, opcode, execute, show.
    task automatic model_edge(input logic e, input logic c,
                              input logic ch, input logic [7:0] v);
        m_done = 0;
        if (c) begin
            m_phase = 0; m_a = 0; m_b = 0; m_sel = 0; m_res = 0;
        end else if (m_phase == 3) begin
            m_res = 16'(int'(m_a) * int'(m_b));
            m_done = 1;
            m_cnt = 8'((int'(m_cnt) + 1) % 256);
            m_phase = 4;
        end else if (e) begin
            if (m_phase == 0) begin m_a = v; m_phase = 1; end
            else if (m_phase == 1) begin m_b = v; m_phase = 2; end
            else if (m_phase == 2) begin m_sel = 3'(v % 8); m_phase = 3; end
            else if (ch) begin m_a = 8'(m_res % 256); m_phase = 1; end
            else m_phase = 0;
        end
    endtask

    task automatic cyc(input logic e, input logic c,
                       input logic ch, input logic [7:0] v);
        @(negedge clk);
        enter = e; clr = c; chain = ch; in = v;
        @(posedge clk);
        model_edge(e, c, ch, v);
        #1;
        enter = 0; clr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 0;
    endtask

    task automatic test_reset();
        in = 8'h5A;
        do_reset();
        total++;
        if (step !== 5'b00001) begin
            bad++; $display("FAIL reset_step got=%b exp=%b", step, 5'b00001);
        end
        total++;
        if ({op_a, op_b, op_sel, result, done, op_count} !== '0) begin
            bad++; $display("FAIL reset_regs got a=%h b=%h s=%h r=%h d=%b c=%h exp=0",
                            op_a, op_b, op_sel, result, done, op_count);
        end
        total++;
        if (disp !== 16'h005A) begin
            bad++; $display("FAIL reset_disp got=%h exp=%h", disp, 16'h005A);
        end
    endtask

    task automatic test_basic();
        cyc(1, 0, 0, 8'h0C);
        cyc(1, 0, 0, 8'h0A);
        cyc(1, 0, 0, 8'h02);
        total++;
        if (op_sel !== 3'd2 || step !== 5'b01000) begin
            bad++; $display("FAIL basic_sel got sel=%0d step=%b exp sel=2 step=01000",
                            op_sel, step);
        end
        cyc(0, 0, 0, 8'h00);
        total++;
        if (result !== 16'h0078 || done !== 1'b1 || op_count !== 8'd1
            || step !== 5'b10000 || disp !== 16'h0078) begin
            bad++; $display("FAIL basic_result got r=%h d=%b c=%0d st=%b disp=%h exp r=0078 d=1 c=1 st=10000",
                            result, done, op_count, step, disp);
        end
        cyc(0, 0, 0, 8'h00);
        total++;
        if (done !== 1'b0 || step !== 5'b10000) begin
            bad++; $display("FAIL basic_done_pulse got d=%b st=%b exp d=0 st=10000", done, step);
        end
    endtask

    task automatic test_chain();
        cyc(1, 0, 1, 8'hEE);
        total++;
        if (op_a !== 8'h78 || step !== 5'b00010) begin
            bad++; $display("FAIL chain_a got a=%h st=%b exp a=78 st=00010", op_a, step);
        end
        cyc(1, 0, 1, 8'h03);
        cyc(1, 0, 1, 8'h00);
        cyc(0, 0, 1, 8'h00);
        total++;
        if (result !== 16'h0168 || op_count !== 8'd2) begin
            bad++; $display("FAIL chain_result got r=%h c=%0d exp r=0168 c=2", result, op_count);
        end
    endtask

    task automatic test_max();
        cyc(1, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'hFF);
        cyc(1, 0, 0, 8'hFF);
        cyc(1, 0, 0, 8'(3'($urandom)));
        cyc(0, 0, 0, 8'h00);
        total++;
        if (result !== 16'hFE01) begin
            bad++; $display("FAIL max_result got=%h exp=FE01", result);
        end
        cyc(1, 0, 1, 8'h00);
        total++;
        if (op_a !== 8'h01) begin
            bad++; $display("FAIL max_trunc got=%h exp=01", op_a);
        end
    endtask

    task automatic test_clr();
        logic [7:0] cnt;
        cnt = op_count;
        cyc(1, 1, 0, 8'h44);
        total++;
        if (step !== 5'b00001 || op_a !== 8'h00 || op_b !== 8'h00
            || result !== 16'h0000 || op_count !== cnt) begin
            bad++; $display("FAIL clr_enter got st=%b a=%h b=%h r=%h c=%0d exp st=00001 a=0 b=0 r=0 c=%0d",
                            step, op_a, op_b, result, op_count, cnt);
        end
    endtask

    task automatic test_exec_enter();
        cyc(1, 0, 0, 8'h07);
        cyc(1, 0, 0, 8'h09);
        cyc(1, 0, 0, 8'h05);
        cyc(1, 0, 0, 8'h33);
        total++;
        if (step !== 5'b10000 || result !== 16'd63 || op_a !== 8'h07) begin
            bad++; $display("FAIL exec_enter got st=%b r=%h a=%h exp st=10000 r=003f a=07",
                            step, result, op_a);
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00);
        total++;
        if (step !== 5'b10000 || done !== 1'b0) begin
            bad++; $display("FAIL exec_hold got st=%b d=%b exp st=10000 d=0", step, done);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_disp;
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
                1'($urandom), 8'($urandom));
            exp_disp = (m_phase < 2) ? {8'h00, in} :
                       (m_phase == 2) ? {13'h0, in[2:0]} : m_res;
            total++;
            if (step !== 5'(1 << m_phase) || op_a !== m_a || op_b !== m_b
                || op_sel !== m_sel || result !== m_res || done !== m_done
                || op_count !== m_cnt || disp !== exp_disp) begin
                bad++;
                if (errs++ < 5)
                    $display("FAIL random_%0d got st=%b a=%h b=%h s=%0d r=%h d=%b c=%0d disp=%h exp ph=%0d a=%h b=%h s=%0d r=%h d=%b c=%0d disp=%h",
                             i, step, op_a, op_b, op_sel, result, done, op_count, disp,
                             m_phase, m_a, m_b, m_sel, m_res, m_done, m_cnt, exp_disp);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int n = 0; n < 256; n++) begin
            cyc(1, 0, 0, 8'($urandom));
            cyc(1, 0, 0, 8'($urandom));
            cyc(1, 0, 0, 8'($urandom));
            cyc(0, 0, 0, 8'h00);
            if (n == 254) begin
                total++;
                if (op_count !== 8'd255) begin
                    bad++; $display("FAIL wrap_255 got=%0d exp=255", op_count);
                end
            end
            cyc(1, 0, 0, 8'h00);
        end
        total++;
        if (op_count !== 8'd0 || op_count !== m_cnt) begin
            bad++; $display("FAIL wrap_0 got=%0d exp=0", op_count);
        end
    endtask

    task automatic test_rst_mid();
        cyc(1, 0, 0, 8'h21);
        cyc(1, 0, 0, 8'h13);
        cyc(1, 0, 0, 8'h04);
        cyc(0, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'h66);
        @(negedge clk);
        enter = 1; in = 8'h3C; rst = 1;
        @(posedge clk);
        model_reset();
        #1;
        enter = 0; rst = 0;
        total++;
        if (step !== 5'b00001 || done !== 1'b0 || disp !== 16'h003C
            || {op_a, op_b, op_sel, result, op_count} !== '0) begin
            bad++; $display("FAIL rst_mid got st=%b d=%b disp=%h a=%h b=%h s=%h r=%h c=%0d exp st=00001 disp=003c rest=0",
                            step, done, disp, op_a, op_b, op_sel, result, op_count);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_chain();
        test_max();
        test_clr();
        test_exec_enter();
        test_random();
        test_wrap();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
